button_event_rx: RTL and testbench

- Input-side counterpart to the board's LED drivers: samples one raw pushbutton pin, synchronises and debounces it, and turns it into clean single-cycle events.
- Events produced: press, release, long-press and (optionally) auto-repeat.
- Also keeps a saturating-free short-click counter that top-level logic can map onto LED1..LED5.
- Sits directly behind a board input pin, in the single clk domain.

---
 rtl/button_event_rx.sv | 229 ++++++++++++++++++++++
 tb/tb_button_event_rx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_rx.sv
// -----------------------------------------------------------------------------
// button_event_rx
//
// Purpose:
//   Samples one raw pushbutton pin, synchronises it into the clk domain,
//   debounces it and emits clean single-cycle events: press, release,
//   long-press and (optionally) auto-repeat. Also counts completed short
//   clicks (presses released before the long-press point), wrapping modulo
//   2^CNT_W, so top-level logic can map the count onto LEDs.
//
// Optional feature:
//   BTN_REPEAT_EN - when defined, repeat_pulse fires every REPEAT_CYCLES
//                   cycles while the button stays held after a long-press.
//                   When undefined, repeat_pulse is tied to 0 and the repeat
//                   timer does not exist.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   btn_raw        in   unsynchronised button pin
//   btn_level      out  debounced pressed state
//   press_pulse    out  one-cycle strobe on accepted press
//   release_pulse  out  one-cycle strobe on accepted release
//   long_pulse     out  one-cycle strobe when the hold reaches LONG_CYCLES
//   repeat_pulse   out  auto-repeat strobe
//   click_count    out  completed short presses, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module button_event_rx #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter int unsigned REPEAT_CYCLES   = 2400000,
  parameter int unsigned TIMER_W         = 24,
  parameter int unsigned CNT_W           = 4,
  parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic             repeat_pulse,
  output logic [CNT_W-1:0] click_count
);

  localparam logic [TIMER_W-1:0] DB_LAST   = TIMER_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYCLES - 1);

  // Elaboration-time sanity checks on the parameter set.
  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
      $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
      $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if ((64'(LONG_CYCLES) - 64'd1) >= (64'd1 << TIMER_W)) begin : g_bad_w
      $error("TIMER_W too narrow for LONG_CYCLES-1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_rep
      $error("REPEAT_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;

  state_t state, state_nxt;

  logic               sync1, sync2, btn_s, pin;
  logic [TIMER_W-1:0] db_cnt, db_nxt;
  logic [TIMER_W-1:0] hold_cnt, hold_nxt;
  logic               long_fired, lf_nxt;
  logic               level_nxt, press_nxt, release_nxt, long_nxt, repeat_nxt;
  logic [CNT_W-1:0]   count_nxt;
`ifdef BTN_REPEAT_EN
  localparam logic [TIMER_W-1:0] REP_LAST = TIMER_W'(REPEAT_CYCLES - 1);
  logic [TIMER_W-1:0] rep_cnt, rep_nxt;
`endif

  // Polarity is corrected before the synchroniser so that reset can force
  // both flops to the "not pressed" level regardless of board wiring.
  assign pin   = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;
  assign btn_s = sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (btn_s) state_nxt = DB_PRESS;
      DB_PRESS:   if (!btn_s) state_nxt = IDLE;
                  else if (db_cnt == DB_LAST) state_nxt = PRESSED;
      PRESSED:    if (!btn_s) state_nxt = DB_RELEASE;
      DB_RELEASE: if (btn_s) state_nxt = PRESSED;
                  else if (db_cnt == DB_LAST) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output and timer logic. All outputs are registered, so this block
  // produces the values they take on the next edge. hold_cnt and rep_cnt
  // are only touched in PRESSED, which freezes them through a release
  // bounce and keeps long_pulse from ever landing on release_pulse.
  always_comb begin
    db_nxt      = db_cnt;
    hold_nxt    = hold_cnt;
    lf_nxt      = long_fired;
    level_nxt   = btn_level;
    count_nxt   = click_count;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
`ifdef BTN_REPEAT_EN
    rep_nxt     = rep_cnt;
`endif
    case (state)
      IDLE: begin
        if (btn_s) db_nxt = '0;
      end
      DB_PRESS: begin
        if (btn_s) begin
          if (db_cnt == DB_LAST) begin
            press_nxt = 1'b1;
            level_nxt = 1'b1;
            hold_nxt  = '0;
            lf_nxt    = 1'b0;
          end else begin
            db_nxt = db_cnt + 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          db_nxt = '0;
        end else begin
          // hold_cnt parks at LONG_LAST; long_fired stops a second strobe.
          if (hold_cnt != LONG_LAST) begin
            hold_nxt = hold_cnt + 1'b1;
          end else if (!long_fired) begin
            long_nxt = 1'b1;
            lf_nxt   = 1'b1;
`ifdef BTN_REPEAT_EN
            rep_nxt  = '0;
`endif
          end
`ifdef BTN_REPEAT_EN
          if (long_fired) begin
            if (rep_cnt == REP_LAST) begin
              repeat_nxt = 1'b1;
              rep_nxt    = '0;
            end else begin
              rep_nxt = rep_cnt + 1'b1;
            end
          end
`endif
        end
      end
      DB_RELEASE: begin
        if (!btn_s) begin
          if (db_cnt == DB_LAST) begin
            release_nxt = 1'b1;
            level_nxt   = 1'b0;
            if (!long_fired) count_nxt = click_count + 1'b1;
          end else begin
            db_nxt = db_cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt        <= '0;
      hold_cnt      <= '0;
      long_fired    <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      click_count   <= '0;
    end else begin
      db_cnt        <= db_nxt;
      hold_cnt      <= hold_nxt;
      long_fired    <= lf_nxt;
      btn_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
      click_count   <= count_nxt;
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rep_cnt      <= rep_nxt;
      repeat_pulse <= repeat_nxt;
    end
  end
`else
  assign repeat_pulse = 1'b0;
  logic unused_repeat;
  assign unused_repeat = repeat_nxt;
`endif

endmodule

// File: tb/tb_button_event_rx.sv
// -----------------------------------------------------------------------------
// tb_button_event_rx
//
// Purpose:
//   Self-checking bench for button_event_rx with small timing parameters.
//   Expected events (kind + edge index) are queued when stimulus is driven;
//   pulses seen on the DUT are queued as they occur and the two queues are
//   compared in each scenario task.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_button_event_rx;

  localparam int DB = 4;
  localparam int LG = 20;
  localparam int RP = 8;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic [3:0] click_count;

  button_event_rx #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG),
    .REPEAT_CYCLES  (RP),
    .TIMER_W        (24),
    .CNT_W          (4),
    .BTN_ACTIVE_LOW (1'b0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .click_count  (click_count)
  );

  always #5 clk = ~clk;

  // Edge index: value after a posedge numbers that edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  failures = 0;
  int  exp_count = 0;

  // Advance n clock edges, sampling 1 time unit after each edge and logging
  // every pulse seen with its edge index.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (press_pulse)   obs_q.push_back(ev_t'{K_PRESS, cyc});
      if (release_pulse) obs_q.push_back(ev_t'{K_RELEASE, cyc});
      if (long_pulse)    obs_q.push_back(ev_t'{K_LONG, cyc});
      if (repeat_pulse)  obs_q.push_back(ev_t'{K_REPEAT, cyc});
    end
  endtask

  // One short click: hi cycles pressed, lo cycles released. The first
  // sampling edge is n; both pulses trail their sampled level by DB+2 edges.
  task automatic click(input int hi, input int lo);
    int n;
    n = cyc + 1;
    exp_q.push_back(ev_t'{K_PRESS, n + DB + 2});
    exp_q.push_back(ev_t'{K_RELEASE, n + hi + DB + 2});
    btn_raw = 1'b1;
    tick(hi);
    btn_raw = 1'b0;
    tick(lo);
  endtask

  task automatic test_reset();
    ev_t e, o;
    rst_n = 1'b0;
    btn_raw = 1'b0;
    tick(3);
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b, want 00000",
               {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse});
    end
    checks++;
    if (click_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_count: got %0d, want 0", click_count);
    end
    rst_n = 1'b1;
    tick(50);
    checks++;
    if (btn_level !== 1'b0 || click_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL idle_outputs: level=%b count=%0d, want 0/0", btn_level, click_count);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.kind !== e.kind || o.at !== e.at) begin
        failures++;
        $display("[TB] FAIL idle_event: got kind=%0d at=%0d, want kind=%0d at=%0d", o.kind, o.at, e.kind, e.at);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL idle_event_count: %0d unmatched observed, %0d unmet expected", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    ev_t e, o;
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    tick(12);
    checks++;
    if (btn_level !== 1'b0 || click_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL glitch_state: level=%b count=%0d, want 0/0", btn_level, click_count);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.kind !== e.kind || o.at !== e.at) begin
        failures++;
        $display("[TB] FAIL glitch_event: got kind=%0d at=%0d, want kind=%0d at=%0d", o.kind, o.at, e.kind, e.at);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL glitch_event_count: %0d unmatched observed, %0d unmet expected", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_short_click();
    ev_t e, o;
    int  n;
    n = cyc + 1;
    exp_q.push_back(ev_t'{K_PRESS, n + 6});
    exp_q.push_back(ev_t'{K_RELEASE, n + 16});
    btn_raw = 1'b1;
    tick(10);
    checks++;
    if (btn_level !== 1'b1) begin
      failures++;
      $display("[TB] FAIL short_level_held: got %b, want 1", btn_level);
    end
    btn_raw = 1'b0;
    tick(20);
    exp_count = (exp_count + 1) % 16;
    checks++;
    if (click_count !== 4'(exp_count) || btn_level !== 1'b0) begin
      failures++;
      $display("[TB] FAIL short_count: count=%0d level=%b, want %0d/0", click_count, btn_level, exp_count);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.kind !== e.kind || o.at !== e.at) begin
        failures++;
        $display("[TB] FAIL short_event: got kind=%0d at=%0d, want kind=%0d at=%0d", o.kind, o.at, e.kind, e.at);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL short_event_count: %0d unmatched observed, %0d unmet expected", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_long_press();
    ev_t e, o;
    int  n;
    n = cyc + 1;
    exp_q.push_back(ev_t'{K_PRESS, n + 6});
    exp_q.push_back(ev_t'{K_LONG, n + 6 + LG});
`ifdef BTN_REPEAT_EN
    exp_q.push_back(ev_t'{K_REPEAT, n + 6 + LG + RP});
    exp_q.push_back(ev_t'{K_REPEAT, n + 6 + LG + 2 * RP});
`endif
    exp_q.push_back(ev_t'{K_RELEASE, n + 44 + 6});
    btn_raw = 1'b1;
    tick(44);
    btn_raw = 1'b0;
    tick(12);
    checks++;
    if (click_count !== 4'(exp_count) || btn_level !== 1'b0) begin
      failures++;
      $display("[TB] FAIL long_count: count=%0d level=%b, want %0d/0", click_count, btn_level, exp_count);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.kind !== e.kind || o.at !== e.at) begin
        failures++;
        $display("[TB] FAIL long_event: got kind=%0d at=%0d, want kind=%0d at=%0d", o.kind, o.at, e.kind, e.at);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL long_event_count: %0d unmatched observed, %0d unmet expected", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // A 2-cycle drop while held keeps the hold timer frozen for 3 edges
  // (enter DB_RELEASE, one debounce step, return to PRESSED).
  task automatic test_release_bounce();
    ev_t e, o;
    int  n;
    n = cyc + 1;
    exp_q.push_back(ev_t'{K_PRESS, n + 6});
    exp_q.push_back(ev_t'{K_LONG, n + 6 + LG + 3});
`ifdef BTN_REPEAT_EN
    exp_q.push_back(ev_t'{K_REPEAT, n + 6 + LG + 3 + RP});
`endif
    exp_q.push_back(ev_t'{K_RELEASE, n + 40 + 6});
    btn_raw = 1'b1;
    tick(10);
    btn_raw = 1'b0;
    tick(2);
    btn_raw = 1'b1;
    tick(3);
    checks++;
    if (btn_level !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bounce_level: got %b, want 1", btn_level);
    end
    tick(25);
    btn_raw = 1'b0;
    tick(12);
    checks++;
    if (click_count !== 4'(exp_count)) begin
      failures++;
      $display("[TB] FAIL bounce_count: got %0d, want %0d", click_count, exp_count);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.kind !== e.kind || o.at !== e.at) begin
        failures++;
        $display("[TB] FAIL bounce_event: got kind=%0d at=%0d, want kind=%0d at=%0d", o.kind, o.at, e.kind, e.at);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL bounce_event_count: %0d unmatched observed, %0d unmet expected", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wrap_and_reset();
    ev_t e, o;
    int  clicks, n;
    clicks = 16 - exp_count;
    for (int i = 0; i < clicks; i++) begin
      click(10, 10);
      exp_count = (exp_count + 1) % 16;
    end
    checks++;
    if (click_count !== 4'(exp_count) || exp_count != 0) begin
      failures++;
      $display("[TB] FAIL wrap_count: got %0d, want 0", click_count);
    end
    n = cyc + 1;
    exp_q.push_back(ev_t'{K_PRESS, n + 6});
    btn_raw = 1'b1;
    tick(10);
    checks++;
    if (btn_level !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midpress_level: got %b, want 1", btn_level);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (btn_level !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset_level: got %b, want 0", btn_level);
    end
    btn_raw = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    checks++;
    if (click_count !== 4'd0 || btn_level !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_state: count=%0d level=%b, want 0/0", click_count, btn_level);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.kind !== e.kind || o.at !== e.at) begin
        failures++;
        $display("[TB] FAIL wrap_event: got kind=%0d at=%0d, want kind=%0d at=%0d", o.kind, o.at, e.kind, e.at);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL wrap_event_count: %0d unmatched observed, %0d unmet expected", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_short_click();
    test_long_press();
    test_release_bounce();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
